// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and the
// address-split widths derived from the cache geometry.
package icache_fetch_pkg;

  // Fetch FSM states: LOOKUP probes the cache, REFILL launches one word
  // read, WAIT holds that read until the memory controller answers.
  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_REFILL = 2'd1,
    ST_WAIT   = 2'd2
  } fetch_state_e;

  // Default geometry: 64 lines of 4 words.
  localparam int DEF_INDEX_BITS        = 6;
  localparam int DEF_OFFSET_WORDS_BITS = 2;

  // Tag width left over after word offset, line index and the byte offset.
  function automatic int calc_tag_bits(input int index_bits, input int offset_words_bits);
    return 32 - index_bits - offset_words_bits - 2;
  endfunction

  // Number of 32-bit words held by one line.
  function automatic int calc_line_words(input int offset_words_bits);
    return 1 << offset_words_bits;
  endfunction

  localparam int TAG_BITS   = calc_tag_bits(DEF_INDEX_BITS, DEF_OFFSET_WORDS_BITS);
  localparam int LINE_WORDS = calc_line_words(DEF_OFFSET_WORDS_BITS);

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: data words, per-line tags and
// valid bits. Reads are combinational; word writes, tag/valid set and
// valid clear happen on the clock edge. Only the valid bits are reset, so
// data and tag storage can map onto plain RAM.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS        = DEF_INDEX_BITS,
  parameter int OFFSET_WORDS_BITS = DEF_OFFSET_WORDS_BITS,
  parameter int TAG_W             = calc_tag_bits(INDEX_BITS, OFFSET_WORDS_BITS)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  // combinational read port
  input  logic [INDEX_BITS-1:0]        rd_index,
  input  logic [OFFSET_WORDS_BITS-1:0] rd_offset,
  input  logic [TAG_W-1:0]             rd_tag,
  output logic                         rd_hit,
  output logic [31:0]                  rd_data,
  // synchronous update port, all operations act on line wr_index
  input  logic [INDEX_BITS-1:0]        wr_index,
  input  logic                         wr_en,
  input  logic [OFFSET_WORDS_BITS-1:0] wr_offset,
  input  logic [31:0]                  wr_data,
  input  logic                         set_valid,
  input  logic [TAG_W-1:0]             set_tag,
  input  logic                         clr_valid
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES << OFFSET_WORDS_BITS;

  logic [31:0]      data_mem [WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  // Read port: a hit needs the line valid and the stored tag equal.
  assign rd_data = data_mem[{rd_index, rd_offset}];
  assign rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);

  // Data and tag writes; no reset needed since valid gates every use.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
    if (set_valid) begin
      tag_mem[wr_index] <= set_tag;
    end
  end

  // Valid bits: cleared at reset and when a refill starts, set when it ends.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (clr_valid) begin
      valid_q[wr_index] <= 1'b0;
    end else if (set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Fetch unit: owns the fetch PC, pushes one instruction per cycle into the
// decode queue on a cache hit, refills missing lines word by word from the
// memory controller and redirects on clear.
//
// Handshakes:
//  - Decode side: have_out is a one-cycle valid for instr_out/instr_pc_out,
//    issued only for a cycle in which IF_not_full was high at the edge.
//  - Memory side: mem_req_out rises with mem_addr_out and both stay stable
//    until the cycle after mem_done_in is sampled high; mem_done_in is a
//    one-cycle pulse carrying mem_data_in. The request drops for at least one
//    cycle between words. An asynchronous reset may withdraw a request.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int          INDEX_BITS        = DEF_INDEX_BITS,
  parameter int          OFFSET_WORDS_BITS = DEF_OFFSET_WORDS_BITS,
  parameter logic [31:0] RESET_PC          = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc_in,
  input  logic        IF_not_full,
  output logic        have_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_data_in
);

  localparam int TAG_W    = calc_tag_bits(INDEX_BITS, OFFSET_WORDS_BITS);
  localparam int LINE_LSB = OFFSET_WORDS_BITS + 2;
  localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;
  localparam logic [OFFSET_WORDS_BITS-1:0] LAST_WORD = '1;

  fetch_state_e                 state_q;
  logic [31:0]                  pc_q;
  logic [OFFSET_WORDS_BITS-1:0] word_q;
  logic                         abort_q;

  logic [OFFSET_WORDS_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]        pc_index;
  logic [TAG_W-1:0]             pc_tag;
  logic [31:0]                  refill_addr;
  logic [31:0]                  pc_plus4;
  logic [31:0]                  redirect_pc;

  logic        line_hit;
  logic [31:0] line_word;
  logic        arr_wr_en;
  logic        arr_set_valid;
  logic        arr_clr_valid;

  // Address split of the current fetch PC.
  assign pc_offset   = pc_q[LINE_LSB-1:2];
  assign pc_index    = pc_q[TAG_LSB-1:LINE_LSB];
  assign pc_tag      = pc_q[31:TAG_LSB];
  assign refill_addr = {pc_q[31:LINE_LSB], word_q, 2'b00};
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {clear_pc_in[31:2], 2'b00};

  // Cache update strobes. A returning word is stored only when the refill
  // has not been aborted by an earlier or coincident clear; the line only
  // becomes valid when its last word lands.
  always_comb begin
    arr_wr_en     = 1'b0;
    arr_set_valid = 1'b0;
    arr_clr_valid = 1'b0;
    if (rdy_in && !clear) begin
      if (state_q == ST_WAIT && mem_done_in && !abort_q) begin
        arr_wr_en     = 1'b1;
        arr_set_valid = (word_q == LAST_WORD);
      end
      if (state_q == ST_LOOKUP && !line_hit) begin
        arr_clr_valid = 1'b1;
      end
    end
  end

  icache_array #(
    .INDEX_BITS        (INDEX_BITS),
    .OFFSET_WORDS_BITS (OFFSET_WORDS_BITS),
    .TAG_W             (TAG_W)
  ) u_array (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rd_index  (pc_index),
    .rd_offset (pc_offset),
    .rd_tag    (pc_tag),
    .rd_hit    (line_hit),
    .rd_data   (line_word),
    .wr_index  (pc_index),
    .wr_en     (arr_wr_en),
    .wr_offset (word_q),
    .wr_data   (mem_data_in),
    .set_valid (arr_set_valid),
    .set_tag   (pc_tag),
    .clr_valid (arr_clr_valid)
  );

  // Fetch FSM with registered decode and memory outputs; rdy_in low freezes
  // everything except have_out, which drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_LOOKUP;
      pc_q         <= RESET_PC;
      word_q       <= '0;
      abort_q      <= 1'b0;
      have_out     <= 1'b0;
      instr_out    <= '0;
      instr_pc_out <= '0;
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
    end else if (!rdy_in) begin
      have_out <= 1'b0;
    end else begin
      have_out <= 1'b0;
      case (state_q)
        ST_LOOKUP: begin
          if (clear) begin
            pc_q <= redirect_pc;
          end else if (line_hit) begin
            if (IF_not_full) begin
              have_out     <= 1'b1;
              instr_out    <= line_word;
              instr_pc_out <= pc_q;
              pc_q         <= pc_plus4;
            end
          end else begin
            word_q  <= '0;
            state_q <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (clear) begin
            pc_q    <= redirect_pc;
            state_q <= ST_LOOKUP;
          end else begin
            mem_req_out  <= 1'b1;
            mem_addr_out <= refill_addr;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_done_in) begin
            mem_req_out <= 1'b0;
            if (clear) begin
              pc_q <= redirect_pc;
            end
            if (abort_q || clear) begin
              abort_q <= 1'b0;
              state_q <= ST_LOOKUP;
            end else if (word_q == LAST_WORD) begin
              state_q <= ST_LOOKUP;
            end else begin
              word_q  <= word_q + 1'b1;
              state_q <= ST_REFILL;
            end
          end else if (clear) begin
            // Request stays on the bus; its data is dropped when it returns.
            pc_q    <= redirect_pc;
            abort_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOOKUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a memory responder returning addr+0x100 after a
// random latency, an output/request monitor, and a cache-residency model
// that predicts the instruction stream and the refill requests.
module tb_icache_fetch;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear;
  logic [31:0] clear_pc_in;
  logic        IF_not_full;
  logic        have_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;

  icache_fetch dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .clear_pc_in  (clear_pc_in),
    .IF_not_full  (IF_not_full),
    .have_out     (have_out),
    .instr_out    (instr_out),
    .instr_pc_out (instr_pc_out),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .mem_done_in  (mem_done_in),
    .mem_data_in  (mem_data_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [31:0] req_log[$];
  logic [31:0] out_pc_q[$];
  logic [31:0] out_instr_q[$];
  int          out_cyc_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_req_q[$];

  // cache residency model: line index -> (valid, tag)
  bit          m_vld[64];
  logic [21:0] m_tag[64];

  bit          hold_en = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  // clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // memory responder: decides shortly after each rising edge
  initial begin
    bit busy;
    bit served;
    int lat;
    busy = 0; served = 0; lat = 0;
    mem_done_in = 1'b0;
    mem_data_in = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      mem_done_in = 1'b0;
      if (!rst_n_in || !mem_req_out) begin
        busy = 0;
        served = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          served = 0;
          lat = $urandom_range(0, 3);
          req_log.push_back(mem_addr_out);
        end
        if (!served) begin
          if (lat > 0) lat--;
          else if (rdy_in && !(hold_en && mem_addr_out == hold_addr)) begin
            mem_done_in = 1'b1;
            mem_data_in = mem_addr_out + 32'h100;
            served = 1;
          end
        end
      end
    end
  end

  // monitor: record emitted instructions, check request address stability
  initial begin
    bit          prev_req;
    logic [31:0] prev_addr;
    prev_req = 0;
    prev_addr = 0;
    forever begin
      @(negedge clk_in);
      cyc_cnt++;
      if (rst_n_in === 1'b1) begin
        if (have_out === 1'b1) begin
          out_pc_q.push_back(instr_pc_out);
          out_instr_q.push_back(instr_out);
          out_cyc_q.push_back(cyc_cnt);
        end
        if (mem_req_out === 1'b1 && prev_req) begin
          checks++;
          if (mem_addr_out !== prev_addr) begin
            errors++;
            $display("FAIL addr_stable: mem_addr_out=%h while request held, required %h", mem_addr_out, prev_addr);
          end
        end
        prev_req = (mem_req_out === 1'b1);
        prev_addr = mem_addr_out;
      end else begin
        prev_req = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_vld[i] = 0;
  endtask

  // Expected stream from start: n instructions, then the fetch parks on the
  // next pc, whose line is also refilled if absent.
  task automatic model_expect(input logic [31:0] start, input int n);
    for (int i = 0; i <= n; i++) begin
      logic [31:0] pc;
      int idx;
      pc = start + 32'(4 * i);
      idx = int'(pc[9:4]);
      if (i < n) exp_q.push_back({pc + 32'h100, pc});
      if (!(m_vld[idx] && m_tag[idx] == pc[31:10])) begin
        for (int w = 0; w < 4; w++) exp_req_q.push_back({pc[31:4], 4'h0} + 32'(4 * w));
        m_vld[idx] = 1;
        m_tag[idx] = pc[31:10];
      end
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_pc_q.delete();
    out_instr_q.delete();
    out_cyc_q.delete();
    exp_q.delete();
    exp_req_q.delete();
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    step();
    step();
    model_reset();
    clear_logs();
    rst_n_in = 1'b1;
  endtask

  task automatic do_clear(input logic [31:0] pc);
    clear = 1'b1;
    clear_pc_in = pc;
    step();
    clear = 1'b0;
  endtask

  // drive IF_not_full until n instructions have been seen, then stall
  task automatic collect(input int n, input bit bp, output bit to);
    int cyc;
    cyc = 0;
    to = 0;
    while (out_pc_q.size() < n && !to) begin
      IF_not_full = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      cyc++;
      if (cyc > 2000) to = 1;
    end
    IF_not_full = 1'b0;
  endtask

  // wait until no refill has been active for a while
  task automatic wait_idle(output bit to);
    int quiet;
    int cyc;
    quiet = 0;
    cyc = 0;
    to = 0;
    while (quiet < 12 && !to) begin
      step();
      quiet = mem_req_out ? 0 : quiet + 1;
      cyc++;
      if (cyc > 3000) to = 1;
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    clear = 1'b0;
    clear_pc_in = 32'h0;
    IF_not_full = 1'b0;
    step();
    step();
    checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL reset_have: got %b need 0", have_out); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h need 0", instr_out); end
    checks++; if (instr_pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h need 0", instr_pc_out); end
    checks++; if (mem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b need 0", mem_req_out); end
    checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h need 0", mem_addr_out); end
  endtask

  task automatic test_cold_start();
    bit to;
    apply_reset();
    model_expect(32'h0, 4);
    collect(4, 0, to);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL cold_timeout: got timeout need progress"); end
    checks++;
    if (out_pc_q.size() != exp_q.size()) begin errors++; $display("FAIL cold_count: got %0d need %0d", out_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_pc_q.size(); i++) begin
      checks++;
      if ({out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL cold_out[%0d]: got %h need %h", i, {out_instr_q[i], out_pc_q[i]}, exp_q[i]); end
      checks++;
      if (out_cyc_q[i] != out_cyc_q[0] + i) begin errors++; $display("FAIL cold_back2back[%0d]: got cycle %0d need %0d", i, out_cyc_q[i], out_cyc_q[0] + i); end
    end
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL cold_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
    for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL cold_req[%0d]: got %h need %h", i, req_log[i], exp_req_q[i]); end
    end
  endtask

  task automatic test_warm_loop();
    bit to;
    clear_logs();
    // parked on a hit at 0x10 with queue space: clear must win over issue
    clear = 1'b1;
    clear_pc_in = 32'h0;
    IF_not_full = 1'b1;
    step();
    clear = 1'b0;
    IF_not_full = 1'b0;
    checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL warm_clear_have: got %b need 0", have_out); end
    model_expect(32'h0, 4);
    collect(4, 0, to);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL warm_timeout: got timeout need progress"); end
    checks++;
    if (out_pc_q.size() != exp_q.size()) begin errors++; $display("FAIL warm_count: got %0d need %0d", out_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_pc_q.size(); i++) begin
      checks++;
      if ({out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL warm_out[%0d]: got %h need %h", i, {out_instr_q[i], out_pc_q[i]}, exp_q[i]); end
      checks++;
      if (out_cyc_q[i] != out_cyc_q[0] + i) begin errors++; $display("FAIL warm_back2back[%0d]: got cycle %0d need %0d", i, out_cyc_q[i], out_cyc_q[0] + i); end
    end
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL warm_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    do_clear(32'h0);
    IF_not_full = 1'b1;
    step();
    IF_not_full = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL bp_stall_have[%0d]: got %b need 0", s, have_out); end
    end
    checks++; if (out_pc_q.size() != 1) begin errors++; $display("FAIL bp_pre_count: got %0d need 1", out_pc_q.size()); end
    model_expect(32'h0, 4);
    collect(4, 0, to);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout need progress"); end
    checks++;
    if (out_pc_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d need %0d", out_pc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_pc_q.size(); i++) begin
      checks++;
      if ({out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL bp_out[%0d]: got %h need %h", i, {out_instr_q[i], out_pc_q[i]}, exp_q[i]); end
    end
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL bp_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
  endtask

  task automatic test_clear_during_wait();
    bit to;
    int cyc;
    IF_not_full = 1'b0;
    hold_en = 1'b1;
    hold_addr = 32'h8;
    apply_reset();
    cyc = 0;
    while (!(req_log.size() >= 3 && mem_req_out && mem_addr_out == 32'h8) && cyc < 500) begin
      step();
      cyc++;
    end
    checks++; if (cyc >= 500) begin errors++; $display("FAIL abort_reach: got no request at 8 need one"); end
    do_clear(32'h40);
    for (int s = 0; s < 3; s++) begin
      checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h8) begin errors++; $display("FAIL abort_hold[%0d]: got req=%b addr=%h need 1/8", s, mem_req_out, mem_addr_out); end
      checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL abort_have[%0d]: got %b need 0", s, have_out); end
      step();
    end
    hold_en = 1'b0;
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL abort_timeout: got timeout need progress"); end
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    model_expect(32'h40, 0);
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL abort_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
    for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL abort_req[%0d]: got %h need %h", i, req_log[i], exp_req_q[i]); end
    end
    // line 0 must still be missing after the aborted refill
    clear_logs();
    do_clear(32'h0);
    model_expect(32'h0, 2);
    collect(2, 0, to);
    wait_idle(to);
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL abort_line0_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
    for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL abort_line0_req[%0d]: got %h need %h", i, req_log[i], exp_req_q[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < out_pc_q.size(); i++) begin
      checks++;
      if ({out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL abort_out[%0d]: got %h need %h", i, {out_instr_q[i], out_pc_q[i]}, exp_q[i]); end
    end
  endtask

  task automatic test_rdy_freeze();
    bit to;
    int cyc;
    clear_logs();
    hold_en = 1'b1;
    hold_addr = 32'h2004;
    do_clear(32'h2000);
    cyc = 0;
    while (!(mem_req_out && mem_addr_out == 32'h2004) && cyc < 500) begin
      step();
      cyc++;
    end
    checks++; if (cyc >= 500) begin errors++; $display("FAIL rdy_reach: got no request at 2004 need one"); end
    rdy_in = 1'b0;
    hold_en = 1'b0;
    IF_not_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      checks++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h2004) begin errors++; $display("FAIL rdy_hold[%0d]: got req=%b addr=%h need 1/2004", s, mem_req_out, mem_addr_out); end
      checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL rdy_have[%0d]: got %b need 0", s, have_out); end
    end
    IF_not_full = 1'b0;
    rdy_in = 1'b1;
    model_expect(32'h2000, 4);
    collect(4, 0, to);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL rdy_timeout: got timeout need progress"); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_pc_q.size() || {out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL rdy_out[%0d]: got %0d outputs, need %h", i, out_pc_q.size(), exp_q[i]); end
    end
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL rdy_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
    for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL rdy_req[%0d]: got %h need %h", i, req_log[i], exp_req_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] start;
    logic [31:0] prev_start;
    int n;
    prev_start = 32'h2000;
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: start = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
        1: start = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        default: start = prev_start;
      endcase
      prev_start = start;
      n = $urandom_range(3, 10);
      clear_logs();
      do_clear(start);
      model_expect(start, n);
      collect(n, 1, to);
      checks++; if (to) begin errors++; $display("FAIL rand_timeout[%0d]: got timeout need %0d outputs", it, n); end
      wait_idle(to);
      checks++;
      if (out_pc_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d need %0d", it, out_pc_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_pc_q.size(); i++) begin
        checks++;
        if ({out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL rand_out[%0d][%0d]: got %h need %h", it, i, {out_instr_q[i], out_pc_q[i]}, exp_q[i]); end
      end
      checks++;
      if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL rand_reqs[%0d]: got %0d need %0d", it, req_log.size(), exp_req_q.size()); end
      for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
        checks++;
        if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL rand_req[%0d][%0d]: got %h need %h", it, i, req_log[i], exp_req_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    bit to;
    int cyc;
    clear_logs();
    hold_en = 1'b1;
    hold_addr = 32'h3008;
    do_clear(32'h3000);
    cyc = 0;
    while (!(mem_req_out && mem_addr_out == 32'h3008) && cyc < 500) begin
      step();
      cyc++;
    end
    checks++; if (cyc >= 500) begin errors++; $display("FAIL rstw_reach: got no request at 3008 need one"); end
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++; if (mem_req_out !== 1'b0) begin errors++; $display("FAIL rstw_req: got %b need 0", mem_req_out); end
    checks++; if (have_out !== 1'b0) begin errors++; $display("FAIL rstw_have: got %b need 0", have_out); end
    hold_en = 1'b0;
    step();
    model_reset();
    clear_logs();
    rst_n_in = 1'b1;
    model_expect(32'h0, 4);
    collect(4, 0, to);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL rstw_timeout: got timeout need progress"); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_pc_q.size() || {out_instr_q[i], out_pc_q[i]} !== exp_q[i]) begin errors++; $display("FAIL rstw_out[%0d]: got %0d outputs, need %h", i, out_pc_q.size(), exp_q[i]); end
    end
    checks++;
    if (req_log.size() != exp_req_q.size()) begin errors++; $display("FAIL rstw_reqs: got %0d need %0d", req_log.size(), exp_req_q.size()); end
    for (int i = 0; i < exp_req_q.size() && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== exp_req_q[i]) begin errors++; $display("FAIL rstw_req[%0d]: got %h need %h", i, req_log[i], exp_req_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_warm_loop();
    test_backpressure();
    test_clear_during_wait();
    test_rdy_freeze();
    test_random();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
